// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encoding,
// requester count, index width and the default grant-hold limit.
package arb_pkg;

    localparam int N_REQ        = 4;
    localparam int IDX_W        = 2;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request starting at last+1,
// wrapping round so that `last` itself is considered last.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] cand;

    // Walk from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        valid  = 1'b0;
        winner = last;
        cand   = last;
        for (int k = N_REQ; k >= 1; k--) begin
            cand   = last + IDX_W'(k);
            valid  = valid | req[cand];
            winner = req[cand] ? cand : winner;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter holding each grant for a whole transaction.
// Optional grant-hold preemption is built when ARB_HOLD_LIMIT_EN is defined.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = MAX_HOLD_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] c_data,
    input  logic [DATA_W-1:0] d_data,
    input  logic              done,
    output logic [N_REQ-1:0]  grant,
    output logic [IDX_W-1:0]  index,
    output logic              busy,
    output logic [DATA_W-1:0] data_out
);

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must lie in 2..255");
    end

    state_t           state_r, state_nx;
    logic [N_REQ-1:0] grant_r, grant_nx;
    logic [IDX_W-1:0] index_r, index_nx;
    logic             busy_r, busy_nx;
    logic [IDX_W-1:0] last_r, last_nx;
    logic             new_grant_s;
    logic             forced_s;
    logic             release_s;
    logic [N_REQ-1:0] pick_req_s;
    logic             pick_valid_s;
    logic [IDX_W-1:0] pick_idx_s;

    // While owning, the owner is excluded so a release hands over without a bubble.
    assign pick_req_s = (state_r == OWN) ? (req & ~grant_r) : req;
    assign release_s  = done | ~req[index_r] | forced_s;

    rr_pick4 u_pick (
        .req    (pick_req_s),
        .last   (last_r),
        .valid  (pick_valid_s),
        .winner (pick_idx_s)
    );

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt_r;

    // Hold counter: cleared on each new grant, saturates at MAX_HOLD-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (new_grant_s) begin
            hold_cnt_r <= 8'd0;
        end else if ((state_r == OWN) && (hold_cnt_r != 8'(MAX_HOLD - 1))) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign forced_s = (hold_cnt_r == 8'(MAX_HOLD - 1)) & pick_valid_s;
`else
    assign forced_s = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= {N_REQ{1'b0}};
            index_r <= {IDX_W{1'b0}};
            busy_r  <= 1'b0;
            last_r  <= IDX_W'(N_REQ - 1);
        end else begin
            state_r <= state_nx;
            grant_r <= grant_nx;
            index_r <= index_nx;
            busy_r  <= busy_nx;
            last_r  <= last_nx;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: state_nx = pick_valid_s ? OWN : IDLE;
            OWN:  state_nx = (release_s && !pick_valid_s) ? IDLE : OWN;
            default: state_nx = IDLE;
        endcase
    end

    // Next grant/index/busy/pointer values.
    always_comb begin
        grant_nx    = grant_r;
        index_nx    = index_r;
        busy_nx     = busy_r;
        last_nx     = last_r;
        new_grant_s = 1'b0;
        case (state_r)
            IDLE: new_grant_s = pick_valid_s;
            OWN:  new_grant_s = release_s & pick_valid_s;
            default: new_grant_s = 1'b0;
        endcase
        if (new_grant_s) begin
            grant_nx = onehot(pick_idx_s);
            index_nx = pick_idx_s;
            busy_nx  = 1'b1;
            last_nx  = pick_idx_s;
        end else if ((state_r != OWN) || release_s) begin
            grant_nx = {N_REQ{1'b0}};
            busy_nx  = 1'b0;
        end else begin
            grant_nx = grant_r;
        end
    end

    // Operand mux; forced to zero while idle.
    always_comb begin
        data_out = {DATA_W{1'b0}};
        if (busy_r) begin
            case (index_r)
                2'd0:    data_out = a_data;
                2'd1:    data_out = b_data;
                2'd2:    data_out = c_data;
                2'd3:    data_out = d_data;
                default: data_out = {DATA_W{1'b0}};
            endcase
        end else begin
            data_out = {DATA_W{1'b0}};
        end
    end

    assign grant = grant_r;
    assign index = index_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed table-driven bench for rr_arbiter4 plus hand-written reset and
// hold-time sequences (ARB_HOLD_LIMIT_EN selects the preemption checks).
module tb_rr_arbiter4;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] index;
        logic       busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic        done = 1'b0;
    logic [31:0] a_data = 32'hAAAA_0000;
    logic [31:0] b_data = 32'hBBBB_1111;
    logic [31:0] c_data = 32'hCCCC_2222;
    logic [31:0] d_data = 32'hDDDD_3333;
    logic [3:0]  grant;
    logic [1:0]  index;
    logic        busy;
    logic [31:0] data_out;

    int total = 0;
    int bad   = 0;
    vec_t vecs[21];

    rr_arbiter4 #(.DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data),
        .done(done), .grant(grant), .index(index), .busy(busy), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [1:0] idx, input logic b);
        logic [31:0] d [4];
        d[0] = 32'hAAAA_0000; d[1] = 32'hBBBB_1111;
        d[2] = 32'hCCCC_2222; d[3] = 32'hDDDD_3333;
        return b ? d[idx] : 32'd0;
    endfunction

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] i, input logic b);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
        chk({tag, ".index"}, {30'd0, index}, {30'd0, i});
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
        chk({tag, ".data"},  data_out, exp_data(i, b));
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rotation with done every other grant edge, then idle/withdraw cases.
        vecs[0]  = '{4'hF,    1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[1]  = '{4'hF,    1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[2]  = '{4'hF,    1'b1, 4'b0010, 2'd1, 1'b1};
        vecs[3]  = '{4'hF,    1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[4]  = '{4'hF,    1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[5]  = '{4'hF,    1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[6]  = '{4'hF,    1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[7]  = '{4'hF,    1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[8]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        vecs[10] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        vecs[11] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[13] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[14] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[15] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        vecs[16] = '{4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0};
        vecs[17] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[18] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[19] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
        vecs[20] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 21; v++) begin
            step(vecs[v].req, vecs[v].done);
            chk_all($sformatf("vec%0d", v), vecs[v].grant, vecs[v].index, vecs[v].busy);
        end

        // Asynchronous reset while requester 2 owns the port.
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'hF, 1'b0);
        chk_all("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_HOLD_LIMIT_EN
        // Requester 0 granted on the previous edge; three more OWN cycles then preemption.
        for (int c = 0; c < 3; c++) begin
            step(4'b0011, 1'b0);
            chk_all($sformatf("hold%0d", c), 4'b0001, 2'd0, 1'b1);
        end
        step(4'b0011, 1'b0);
        chk_all("preempt", 4'b0010, 2'd1, 1'b1);
        step(4'b0001, 1'b0);
        chk_all("back_to0", 4'b0001, 2'd0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(4'b0001, 1'b0);
            chk_all($sformatf("solo%0d", c), 4'b0001, 2'd0, 1'b1);
        end
`else
        for (int c = 0; c < 20; c++) begin
            step(4'b0011, 1'b0);
            chk_all($sformatf("nolimit%0d", c), 4'b0001, 2'd0, 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
